alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: none; all widths are fixed (operand 8 bits, opcode 3 bits, 2 requesters).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept strobe; one-hot or zero.
REQ-006 req_oper0/req_oper1  input  3  opcode from requester 0/1.
REQ-007 req_a0/req_a1, req_b0/req_b1  input  8  operands from requester 0/1.
REQ-008 req_cin  input  2  carry-in per requester.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer accept.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_sum  output  8  ALU result; rsp_cout  output  1  ALU carry-out.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, EXEC, HOLD, with one operation in flight at most.
REQ-015 IDLE: if any req_valid bit is set, the block SHALL assert req_ready for exactly the granted requester in that same cycle, latch its opcode/operands/cin/id, and go to EXEC; otherwise it stays in IDLE with req_ready=0.
REQ-016 Arbitration SHALL be round-robin: a single-valid request is granted directly; when both are valid, the requester not granted last SHALL win; the last-grant pointer updates only on a grant.
REQ-017 EXEC: the block SHALL register the ALU output of the latched operands into rsp_sum/rsp_cout, set rsp_valid=1, and go to HOLD (request-to-rsp_valid latency exactly 2 cycles).
REQ-018 HOLD: rsp_valid, rsp_id, rsp_sum, rsp_cout SHALL remain stable until rsp_valid&&rsp_ready; on that edge rsp_valid clears and state returns to IDLE.
REQ-019 req_ready SHALL be 0 in EXEC and HOLD; a request arriving there is held by its requester and arbitrated in the next IDLE cycle (throughput: 1 op per 3 cycles at best).
REQ-020 Opcodes: 000 ADD {cout,sum}=a+b+cin; 001 SUB {cout,sum}=a+~b+cin (cin=1 gives a-b, cout=1 when no borrow); 010 AND; 011 OR; 100 XOR; 101 NOT a; 110 SHL sum={a[6:0],cin}, cout=a[7]; 111 SHR sum={cin,a[7:1]}, cout=a[0]; logic ops SHALL give cout=0.
REQ-021 All arithmetic SHALL be 9-bit unsigned with bit 8 as cout; no overflow flag.
REQ-022 Operand/opcode changes on req_* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-024 Reset asserted in EXEC or HOLD SHALL discard the in-flight operation without emitting a response.

Structure
REQ-025 A shared package SHALL hold the 3-bit opcode constants, the FSM state encoding, and the operand width constant 8.
REQ-026 The combinational ALU SHALL be one sub-module, alu_core (oper, a, b, c_in -> sum, c_out), instantiated once; the arbiter holds all sequential state.

Verification
REQ-027 Req0 only, ADD a=0xD2 b=0xB6 cin=0 -> req_ready=2'b01 same cycle, rsp_valid 2 cycles later, rsp_sum=0x88, rsp_cout=1, rsp_id=0.
REQ-028 Req1 only, SUB a=0xD2 b=0xB6 cin=1 -> rsp_sum=0x1C, rsp_cout=1, rsp_id=1; SHR a=0xD2 cin=1 -> rsp_sum=0xE9, rsp_cout=0.
REQ-029 Both valid continuously after reset, four ops -> grants in order 0,1,0,1; rsp_id matches each.
REQ-030 rsp_ready held low 5 cycles in HOLD -> outputs stable, req_ready=0 throughout, new grant only on IDLE cycle after acceptance.
REQ-031 rst_n pulsed low during EXEC -> all outputs zero immediately, no rsp_valid afterwards, next tie granted to requester 0.
REQ-032 All 8 opcodes with a=0xFF b=0x01 cin=1 -> results match REQ-020 (ADD 0x01/cout 1, AND 0x01, OR 0xFF, XOR 0xFE, NOT 0x00, SHL 0xFF/cout 1).

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: widths, opcodes, FSM encoding.
package alu_arbiter_pkg;

  localparam int unsigned OperandWidth = 8;
  localparam int unsigned OpcodeWidth  = 3;
  localparam int unsigned NumReq       = 2;

  localparam logic [OpcodeWidth-1:0] OpAdd = 3'b000;
  localparam logic [OpcodeWidth-1:0] OpSub = 3'b001;
  localparam logic [OpcodeWidth-1:0] OpAnd = 3'b010;
  localparam logic [OpcodeWidth-1:0] OpOr  = 3'b011;
  localparam logic [OpcodeWidth-1:0] OpXor = 3'b100;
  localparam logic [OpcodeWidth-1:0] OpNot = 3'b101;
  localparam logic [OpcodeWidth-1:0] OpShl = 3'b110;
  localparam logic [OpcodeWidth-1:0] OpShr = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StHold = 2'b10
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between requesters, the arbiter and the result consumer.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic [NumReq-1:0]       req_valid;
  logic [NumReq-1:0]       req_ready;
  logic [OpcodeWidth-1:0]  req_oper0;
  logic [OpcodeWidth-1:0]  req_oper1;
  logic [OperandWidth-1:0] req_a0;
  logic [OperandWidth-1:0] req_a1;
  logic [OperandWidth-1:0] req_b0;
  logic [OperandWidth-1:0] req_b1;
  logic [NumReq-1:0]       req_cin;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [OperandWidth-1:0] rsp_sum;
  logic                    rsp_cout;
  logic                    busy;

  // Requester/consumer side
  modport master (
    output req_valid, req_oper0, req_oper1, req_a0, req_a1, req_b0, req_b1, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_oper0, req_oper1, req_a0, req_a1, req_b0, req_b1, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational 8-bit ALU; bit 8 of the 9-bit result is the carry-out.
module alu_core
  import alu_arbiter_pkg::*;
(
  input  logic [OpcodeWidth-1:0]  i_oper,
  input  logic [OperandWidth-1:0] i_a,
  input  logic [OperandWidth-1:0] i_b,
  input  logic                    i_c_in,
  output logic [OperandWidth-1:0] o_sum,
  output logic                    o_c_out
);

  logic [OperandWidth:0] w_res;
  logic [OperandWidth:0] w_a_ext;
  logic [OperandWidth:0] w_b_ext;
  logic [OperandWidth:0] w_c_ext;

  assign w_a_ext = {1'b0, i_a};
  assign w_b_ext = {1'b0, i_b};
  assign w_c_ext = {{OperandWidth{1'b0}}, i_c_in};

  // Decode opcode into a 9-bit {cout, sum}; logic ops leave cout at zero
  always_comb begin
    w_res = '0;
    case (i_oper)
      OpAdd:   w_res = w_a_ext + w_b_ext + w_c_ext;
      // a + ~b + cin: with cin=1 this is a-b and cout means "no borrow"
      OpSub:   w_res = w_a_ext + {1'b0, ~i_b} + w_c_ext;
      OpAnd:   w_res = {1'b0, i_a & i_b};
      OpOr:    w_res = {1'b0, i_a | i_b};
      OpXor:   w_res = {1'b0, i_a ^ i_b};
      OpNot:   w_res = {1'b0, ~i_a};
      OpShl:   w_res = {i_a[OperandWidth-1], i_a[OperandWidth-2:0], i_c_in};
      OpShr:   w_res = {i_a[0], i_c_in, i_a[OperandWidth-1:1]};
      default: w_res = '0;
    endcase
  end

  assign o_sum   = w_res[OperandWidth-1:0];
  assign o_c_out = w_res[OperandWidth];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU; one operation in flight.
// IDLE grants and latches, EXEC registers the ALU result, HOLD waits for the consumer.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic                    r_last;
  logic [OpcodeWidth-1:0]  r_oper;
  logic [OperandWidth-1:0] r_a;
  logic [OperandWidth-1:0] r_b;
  logic                    r_cin;
  logic                    r_id;
  logic                    r_rsp_valid;
  logic                    r_rsp_id;
  logic [OperandWidth-1:0] r_rsp_sum;
  logic                    r_rsp_cout;

  logic                    w_any_valid;
  logic                    w_grant_id;
  logic [NumReq-1:0]       w_req_ready;
  logic                    w_accept;
  logic                    w_rsp_taken;
  logic [OpcodeWidth-1:0]  w_sel_oper;
  logic [OperandWidth-1:0] w_sel_a;
  logic [OperandWidth-1:0] w_sel_b;
  logic                    w_sel_cin;
  logic [OperandWidth-1:0] w_alu_sum;
  logic                    w_alu_cout;

  assign w_any_valid = |bus.req_valid;

  // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last
  always_comb begin
    w_grant_id = 1'b0;
    case (bus.req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last;
      default: w_grant_id = 1'b0;
    endcase
  end

  // Operand mux for the requester being granted this cycle
  always_comb begin
    w_sel_oper = bus.req_oper0;
    w_sel_a    = bus.req_a0;
    w_sel_b    = bus.req_b0;
    w_sel_cin  = bus.req_cin[0];
    if (w_grant_id) begin
      w_sel_oper = bus.req_oper1;
      w_sel_a    = bus.req_a1;
      w_sel_b    = bus.req_b1;
      w_sel_cin  = bus.req_cin[1];
    end
  end

  // Next-state and handshake strobes
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_rsp_taken = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_any_valid) begin
          w_accept    = 1'b1;
          w_req_ready = w_grant_id ? 2'b10 : 2'b01;
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        w_state_nxt = StHold;
      end
      StHold: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_taken = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the granted operation and advance the round-robin pointer on grants only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_oper <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_id   <= 1'b0;
    end else if (w_accept) begin
      r_last <= w_grant_id;
      r_oper <= w_sel_oper;
      r_a    <= w_sel_a;
      r_b    <= w_sel_b;
      r_cin  <= w_sel_cin;
      r_id   <= w_grant_id;
    end
  end

  alu_core u_alu_core (
    .i_oper  (r_oper),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_c_in  (r_cin),
    .o_sum   (w_alu_sum),
    .o_c_out (w_alu_cout)
  );

  // Response registers: captured in EXEC, frozen through HOLD, valid drops on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
    end else if (r_state == StExec) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_id;
      r_rsp_sum   <= w_alu_sum;
      r_rsp_cout  <= w_alu_cout;
    end else if (w_rsp_taken) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table for single requests plus hand sequences
// for round-robin ties, a stalled consumer and reset during execution.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  alu_arbiter_if u_if ();

  alu_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [2:0] oper;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic c);
    if (id == 0) begin
      u_if.req_oper0  = op;
      u_if.req_a0     = a;
      u_if.req_b0     = b;
      u_if.req_cin[0] = c;
    end else begin
      u_if.req_oper1  = op;
      u_if.req_a1     = a;
      u_if.req_b1     = b;
      u_if.req_cin[1] = c;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    u_if.req_valid = 2'b00;
    u_if.rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One single-requester transaction; operands are scrambled right after acceptance
  task automatic run_vec(input int idx, input vec_t v);
    int id;
    id = v.valid[1] ? 1 : 0;
    @(negedge clk);
    u_if.req_valid = v.valid;
    u_if.rsp_ready = 1'b0;
    set_req(id, v.oper, v.a, v.b, v.cin);
    set_req(1 - id, 3'b101, 8'h5A, 8'hA5, ~v.cin);
    #1;
    chk($sformatf("v%0d_ready", idx), {14'd0, u_if.req_ready}, {14'd0, v.valid});
    chk($sformatf("v%0d_busy_idle", idx), {15'd0, u_if.busy}, 16'd0);
    @(negedge clk);
    u_if.req_valid = 2'b00;
    set_req(id, v.oper ^ 3'b111, ~v.a, ~v.b, ~v.cin);
    #1;
    chk($sformatf("v%0d_exec_valid", idx), {15'd0, u_if.rsp_valid}, 16'd0);
    chk($sformatf("v%0d_exec_busy", idx), {15'd0, u_if.busy}, 16'd1);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_rsp_valid", idx), {15'd0, u_if.rsp_valid}, 16'd1);
    chk($sformatf("v%0d_rsp_id", idx), {15'd0, u_if.rsp_id}, id[15:0]);
    chk($sformatf("v%0d_sum", idx), {8'd0, u_if.rsp_sum}, {8'd0, v.exp_sum});
    chk($sformatf("v%0d_cout", idx), {15'd0, u_if.rsp_cout}, {15'd0, v.exp_cout});
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;
    #1;
    chk($sformatf("v%0d_rsp_clear", idx), {15'd0, u_if.rsp_valid}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{2'b01, 3'b000, 8'hD2, 8'hB6, 1'b0, 8'h88, 1'b1};
    vecs[1]  = '{2'b10, 3'b001, 8'hD2, 8'hB6, 1'b1, 8'h1C, 1'b1};
    vecs[2]  = '{2'b10, 3'b111, 8'hD2, 8'hB6, 1'b1, 8'hE9, 1'b0};
    vecs[3]  = '{2'b01, 3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1};
    vecs[4]  = '{2'b10, 3'b001, 8'hFF, 8'h01, 1'b1, 8'hFE, 1'b1};
    vecs[5]  = '{2'b01, 3'b010, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{2'b10, 3'b011, 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b0};
    vecs[7]  = '{2'b01, 3'b100, 8'hFF, 8'h01, 1'b1, 8'hFE, 1'b0};
    vecs[8]  = '{2'b10, 3'b101, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{2'b01, 3'b110, 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b1};
    vecs[10] = '{2'b10, 3'b111, 8'hFF, 8'h01, 1'b1, 8'hFF, 1'b1};

    rst_n          = 1'b0;
    u_if.req_valid = 2'b00;
    u_if.rsp_ready = 1'b0;
    set_req(0, 3'b000, 8'h00, 8'h00, 1'b0);
    set_req(1, 3'b000, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {14'd0, u_if.req_ready}, 16'd0);
    chk("rst_rsp_valid", {15'd0, u_if.rsp_valid}, 16'd0);
    chk("rst_rsp_id", {15'd0, u_if.rsp_id}, 16'd0);
    chk("rst_rsp_sum", {8'd0, u_if.rsp_sum}, 16'd0);
    chk("rst_rsp_cout", {15'd0, u_if.rsp_cout}, 16'd0);
    chk("rst_busy", {15'd0, u_if.busy}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    u_if.req_valid = 2'b11;
    u_if.rsp_ready = 1'b1;
    set_req(0, 3'b000, 8'h10, 8'h20, 1'b0);
    set_req(1, 3'b100, 8'h0F, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_ready", k), {14'd0, u_if.req_ready},
          (k % 2 == 1) ? 16'd2 : 16'd1);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_exec_ready", k), {14'd0, u_if.req_ready}, 16'd0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_rsp_valid", k), {15'd0, u_if.rsp_valid}, 16'd1);
      chk($sformatf("rr%0d_rsp_id", k), {15'd0, u_if.rsp_id}, (k % 2 == 1) ? 16'd1 : 16'd0);
      chk($sformatf("rr%0d_sum", k), {8'd0, u_if.rsp_sum},
          (k % 2 == 1) ? 16'h00F0 : 16'h0030);
      @(negedge clk);
    end
    u_if.req_valid = 2'b00;
    u_if.rsp_ready = 1'b0;

    // Consumer stalls five HOLD cycles while requester 1 waits
    do_reset();
    @(negedge clk);
    u_if.req_valid = 2'b01;
    set_req(0, 3'b011, 8'h0F, 8'hF0, 1'b0);
    #1;
    chk("st_ready0", {14'd0, u_if.req_ready}, 16'd1);
    @(negedge clk);
    u_if.req_valid = 2'b10;
    set_req(0, 3'b000, 8'h00, 8'h00, 1'b0);
    set_req(1, 3'b010, 8'hF0, 8'h3C, 1'b0);
    #1;
    chk("st_exec_ready", {14'd0, u_if.req_ready}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("st_hold%0d_valid", i), {15'd0, u_if.rsp_valid}, 16'd1);
      chk($sformatf("st_hold%0d_sum", i), {8'd0, u_if.rsp_sum}, 16'h00FF);
      chk($sformatf("st_hold%0d_id", i), {15'd0, u_if.rsp_id}, 16'd0);
      chk($sformatf("st_hold%0d_cout", i), {15'd0, u_if.rsp_cout}, 16'd0);
      chk($sformatf("st_hold%0d_ready", i), {14'd0, u_if.req_ready}, 16'd0);
    end
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;
    #1;
    chk("st_after_valid", {15'd0, u_if.rsp_valid}, 16'd0);
    chk("st_after_ready", {14'd0, u_if.req_ready}, 16'd2);
    chk("st_after_busy", {15'd0, u_if.busy}, 16'd0);
    @(negedge clk);
    u_if.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("st_r1_valid", {15'd0, u_if.rsp_valid}, 16'd1);
    chk("st_r1_id", {15'd0, u_if.rsp_id}, 16'd1);
    chk("st_r1_sum", {8'd0, u_if.rsp_sum}, 16'h0030);
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;

    // Reset during EXEC: drop the in-flight op and restore the tie pointer
    @(negedge clk);
    u_if.req_valid = 2'b01;
    set_req(0, 3'b000, 8'h01, 8'h01, 1'b0);
    #1;
    chk("rx_ready", {14'd0, u_if.req_ready}, 16'd1);
    @(negedge clk);
    u_if.req_valid = 2'b00;
    #1;
    chk("rx_exec_busy", {15'd0, u_if.busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rx_busy", {15'd0, u_if.busy}, 16'd0);
    chk("rx_rsp_valid", {15'd0, u_if.rsp_valid}, 16'd0);
    chk("rx_rsp_sum", {8'd0, u_if.rsp_sum}, 16'd0);
    chk("rx_rsp_id", {15'd0, u_if.rsp_id}, 16'd0);
    chk("rx_rsp_cout", {15'd0, u_if.rsp_cout}, 16'd0);
    chk("rx_req_ready", {14'd0, u_if.req_ready}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rx_quiet%0d", i), {15'd0, u_if.rsp_valid}, 16'd0);
    end
    u_if.req_valid = 2'b11;
    set_req(0, 3'b001, 8'h05, 8'h03, 1'b1);
    set_req(1, 3'b000, 8'h40, 8'h40, 1'b0);
    #1;
    chk("rx_tie_ready", {14'd0, u_if.req_ready}, 16'd1);
    @(negedge clk);
    u_if.req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("rx_rsp_id2", {15'd0, u_if.rsp_id}, 16'd0);
    chk("rx_rsp_sum2", {8'd0, u_if.rsp_sum}, 16'h0002);
    chk("rx_rsp_cout2", {15'd0, u_if.rsp_cout}, 16'd1);
    u_if.rsp_ready = 1'b1;
    @(negedge clk);
    u_if.rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
